// File: rtl/column_scheduler_if.sv
`timescale 1ns/1ps
// column_scheduler_if: bundles the slot/mask/ready inputs and the column
// strobe outputs of column_scheduler. The master modport is the scheduler
// side; the slave modport is the environment (col_calc, frame sources,
// HUB75 driver).
//
// Handshake: hub75_ready is a level from the driver. Each rising edge is
// one request for the next column pair; requests are latched, never lost,
// and at most one is outstanding. The scheduler answers a request with a
// single-cycle load_col/data_valid pulse carrying col_num1/col_num2. The
// driver applies no backpressure to that pulse.
interface column_scheduler_if #(
    parameter int ROTATIONAL_RES = 256,
    parameter int SCAN_RATE      = 32
);
    localparam int RW = $clog2(ROTATIONAL_RES);
    localparam int CW = $clog2(SCAN_RATE);

    logic [RW-1:0]        dtheta;
    logic [SCAN_RATE-1:0] col_mask;
    logic                 hub75_ready;
    logic [CW-1:0]        gen_col_index;
    logic                 load_col;
    logic [CW-1:0]        col_num1;
    logic [CW:0]          col_num2;
    logic                 data_valid;
    logic                 sweep_done;
    logic [15:0]          abort_count;
    // Current sequencer state, exported for observation only.
    logic [1:0]           state_dbg;

    modport master (
        input  dtheta, col_mask, hub75_ready,
        output gen_col_index, load_col, col_num1, col_num2, data_valid,
               sweep_done, abort_count, state_dbg
    );

    modport slave (
        output dtheta, col_mask, hub75_ready,
        input  gen_col_index, load_col, col_num1, col_num2, data_valid,
               sweep_done, abort_count, state_dbg
    );
endinterface

// File: rtl/column_scheduler.sv
`timescale 1ns/1ps
// column_scheduler: control-only sequencer for the two-column HUB75 stream.
// For every rotational slot it walks the masked column pairs, presents the
// index to the frame sources, waits out the generator latency and then
// strobes one pair per rising edge of hub75_ready.
// Optional feature: define COLUMN_SCHED_STATS_EN to count aborted sweeps.
module column_scheduler #(
    parameter int ROTATIONAL_RES = 256,
    parameter int SCAN_RATE      = 32,
    parameter int GEN_LATENCY    = 2
) (
    input logic                clk_in,
    input logic                rst_in,
    column_scheduler_if.master bus
);
    localparam int RW = $clog2(ROTATIONAL_RES);
    localparam int CW = $clog2(SCAN_RATE);
    localparam int LW = $clog2(GEN_LATENCY + 1);
    localparam logic [CW-1:0] LAST_PTR = CW'(SCAN_RATE - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(GEN_LATENCY - 1);
    localparam logic [CW:0]   PAIR_OFS = (CW + 1)'(SCAN_RATE);

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        WAIT_GEN   = 2'd1,
        WAIT_READY = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] ptr, ptr_nxt;
    logic [LW-1:0] lat_cnt, lat_cnt_nxt;
    logic [RW-1:0] old_dtheta;
    logic          ready_prev;
    logic          ready_pending, pending_nxt;
    logic          emit;
    logic          slot_change;
    logic          ready_edge;
    logic          load_col_q, data_valid_q;
    logic [CW-1:0] col_num1_q;
    logic [CW:0]   col_num2_q;

    assign slot_change = (bus.dtheta != old_dtheta);
    assign ready_edge  = bus.hub75_ready & ~ready_prev;

    // Next-state logic: a slot change overrides everything, including an
    // emission that would otherwise happen this cycle.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        lat_cnt_nxt = lat_cnt;
        emit        = 1'b0;
        if (slot_change) begin
            state_nxt = SCAN;
            ptr_nxt   = '0;
        end else begin
            case (state)
                SCAN: begin
                    if (bus.col_mask[ptr]) begin
                        state_nxt   = WAIT_GEN;
                        lat_cnt_nxt = '0;
                    end else if (ptr == LAST_PTR) begin
                        state_nxt = DONE;
                    end else begin
                        ptr_nxt = ptr + 1'b1;
                    end
                end
                WAIT_GEN: begin
                    lat_cnt_nxt = lat_cnt + 1'b1;
                    if (lat_cnt == LAT_LAST) state_nxt = WAIT_READY;
                end
                WAIT_READY: begin
                    if (ready_pending) begin
                        emit = 1'b1;
                        if (ptr == LAST_PTR) begin
                            state_nxt = DONE;
                        end else begin
                            ptr_nxt   = ptr + 1'b1;
                            state_nxt = SCAN;
                        end
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = SCAN;
                end
            endcase
        end
        // A new edge wins over the clear so a request arriving during an
        // emission is kept for the next pair.
        pending_nxt = ready_edge | (ready_pending & ~emit);
    end

    // State, pointer, edge tracking and registered output strobes.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= SCAN;
            ptr           <= '0;
            lat_cnt       <= '0;
            old_dtheta    <= '0;
            ready_prev    <= 1'b0;
            ready_pending <= 1'b0;
            load_col_q    <= 1'b0;
            data_valid_q  <= 1'b0;
            col_num1_q    <= '0;
            col_num2_q    <= '0;
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            lat_cnt       <= lat_cnt_nxt;
            old_dtheta    <= bus.dtheta;
            ready_prev    <= bus.hub75_ready;
            ready_pending <= pending_nxt;
            load_col_q    <= emit;
            data_valid_q  <= emit;
            if (emit) begin
                col_num1_q <= ptr;
                col_num2_q <= {1'b0, ptr} + PAIR_OFS;
            end
        end
    end

    assign bus.gen_col_index = ptr;
    assign bus.load_col      = load_col_q;
    assign bus.data_valid    = data_valid_q;
    assign bus.col_num1      = col_num1_q;
    assign bus.col_num2      = col_num2_q;
    assign bus.sweep_done    = (state == DONE);
    assign bus.state_dbg     = state;

`ifdef COLUMN_SCHED_STATS_EN
    logic [15:0] abort_cnt;

    // Count sweeps cut short by a slot change; saturates instead of wrapping.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            abort_cnt <= 16'd0;
        end else if (slot_change && (state != DONE) && (abort_cnt != 16'hFFFF)) begin
            abort_cnt <= abort_cnt + 16'd1;
        end
    end

    assign bus.abort_count = abort_cnt;
`else
    assign bus.abort_count = 16'd0;
`endif
endmodule

// File: tb/tb_column_scheduler.sv
`timescale 1ns/1ps
// tb_column_scheduler: randomized and directed stimulus against a
// behavioural model of the column sweep, compared every cycle.
module tb_column_scheduler;
    localparam int RR = 256;
    localparam int SR = 32;
    localparam int GL = 4;
`ifdef COLUMN_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    column_scheduler_if #(.ROTATIONAL_RES(RR), .SCAN_RATE(SR)) bus ();

    column_scheduler #(.ROTATIONAL_RES(RR), .SCAN_RATE(SR), .GEN_LATENCY(GL)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int ncyc  = 0;
    logic [4:0] exp_q[$];
    logic [4:0] got_q[$];
    int         t_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pair cursor walks the mask one bit per cycle; a found pair becomes
    // eligible GL+1 cycles after it was found and fires on a latched request.
    int         m_cyc = 0;
    int         m_cursor = 0;
    int         m_ready_at = 0;
    bit         m_found = 0, m_done = 0, m_pend = 0, m_prev_rdy = 0, m_dv = 0;
    int         m_c1 = 0, m_c2 = 0, m_abort = 0;
    logic [7:0] m_theta = '0;

    task automatic model_step();
        bit edge_now, fire;
        m_cyc++;
        edge_now   = bus.hub75_ready && !m_prev_rdy;
        m_prev_rdy = bus.hub75_ready;
        fire = 0;
        m_dv = 0;
        if (bus.dtheta != m_theta) begin
            if (STATS && !m_done && m_abort != 16'hFFFF) m_abort++;
            m_cursor = 0;
            m_found  = 0;
            m_done   = 0;
        end else if (!m_done) begin
            if (m_found) begin
                if (m_cyc >= m_ready_at && m_pend) begin
                    fire = 1;
                    m_dv = 1;
                    m_c1 = m_cursor;
                    m_c2 = m_cursor + SR;
                    exp_q.push_back(5'(m_cursor));
                    m_found = 0;
                    if (m_cursor == SR - 1) m_done = 1;
                    else m_cursor++;
                end
            end else if (bus.col_mask[m_cursor]) begin
                m_found    = 1;
                m_ready_at = m_cyc + 1 + GL;
            end else if (m_cursor == SR - 1) begin
                m_done = 1;
            end else begin
                m_cursor++;
            end
        end
        m_theta = bus.dtheta;
        m_pend  = edge_now || (m_pend && !fire);
    endtask

    initial forever begin
        @(posedge clk_in or posedge rst_in);
        if (rst_in) begin
            m_cursor = 0; m_found = 0; m_done = 0; m_pend = 0; m_prev_rdy = 0;
            m_dv = 0; m_c1 = 0; m_c2 = 0; m_abort = 0; m_theta = '0;
            exp_q.delete();
        end else begin
            model_step();
        end
    end

    // ---------------- compare / scoreboard ----------------
    int         stab = 0;
    logic [4:0] gen_prev = '0;

    initial forever begin
        @(negedge clk_in);
        ncyc++;
        if (rst_in) begin
            stab = 0;
        end else begin
            check("data_valid", bus.data_valid, m_dv);
            check("load_col", bus.load_col, m_dv);
            check("col_num1", bus.col_num1, m_c1);
            check("col_num2", bus.col_num2, m_c2);
            check("gen_col_index", bus.gen_col_index, m_cursor);
            check("sweep_done", bus.sweep_done, m_done);
            check("abort_count", bus.abort_count, m_abort);
            if (bus.data_valid) begin
                if (exp_q.size() == 0) check("sb_empty", 1, 0);
                else check("sb_col", bus.col_num1, exp_q.pop_front());
                got_q.push_back(bus.col_num1);
                t_q.push_back(ncyc);
            end
            if (bus.load_col) check("gen_stable", (stab >= GL), 1);
            if (bus.gen_col_index == gen_prev) stab++;
            else stab = 1;
            gen_prev = bus.gen_col_index;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    // Raise ready for one cycle at a time while a pair waits on the generator.
    task automatic pulse_loop(input int cycles, input int stop_count);
        for (int c = 0; c < cycles; c++) begin
            step();
            if (got_q.size() >= stop_count) break;
            if (bus.state_dbg == 2'd1 && !bus.hub75_ready) bus.hub75_ready = 1'b1;
            else bus.hub75_ready = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        bit hit;
        bus.dtheta      = '0;
        bus.col_mask    = '0;
        bus.hub75_ready = 1'b0;
        rst_in          = 1'b1;
        repeat (3) step();
        check("rst_dv", bus.data_valid, 0);
        check("rst_load", bus.load_col, 0);
        check("rst_c1", bus.col_num1, 0);
        check("rst_c2", bus.col_num2, 0);
        check("rst_gen", bus.gen_col_index, 0);
        check("rst_done", bus.sweep_done, 0);
        check("rst_abort", bus.abort_count, 0);
        rst_in = 1'b0;
        repeat (40) step();

        // Sparse mask, slow ready toggle.
        got_q.delete();
        bus.dtheta   = 8'd1;
        bus.col_mask = 32'h0000_0005;
        for (int c = 0; c < 300; c++) begin
            step();
            if (c % 10 == 9) bus.hub75_ready = ~bus.hub75_ready;
        end
        check("t1_count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            check("t1_first", got_q[0], 0);
            check("t1_second", got_q[1], 2);
        end
        check("t1_c2", bus.col_num2, 34);
        check("t1_done", bus.sweep_done, 1);

        // Empty mask: sweep completes with no emission.
        got_q.delete();
        bus.hub75_ready = 1'b0;
        bus.col_mask    = '0;
        bus.dtheta      = 8'd2;
        k = -1;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (bus.sweep_done) begin
                k = c;
                break;
            end
        end
        check("t2_latency", k - 1, 32);
        repeat (5) step();
        check("t2_no_dv", got_q.size(), 0);

        // Full mask, ready edges during generator wait.
        got_q.delete();
        t_q.delete();
        bus.col_mask = '1;
        bus.dtheta   = 8'd3;
        pulse_loop(400, 32);
        check("t3_count", got_q.size(), 32);
        if (got_q.size() == 32) begin
            for (int i = 0; i < 32; i++) check("t3_order", got_q[i], i);
            check("t3_span", t_q[31] - t_q[0], 31 * 6);
        end
        repeat (3) step();
        check("t3_done", bus.sweep_done, 1);

        // Slot change on the emission cycle of pair 3.
        got_q.delete();
        bus.dtheta = 8'd5;
        pulse_loop(100, 3);
        hit = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (bus.state_dbg == 2'd2 && bus.gen_col_index == 5'd3) begin
                bus.dtheta      = 8'd6;
                bus.hub75_ready = 1'b0;
                hit = 1;
                break;
            end
            if (bus.state_dbg == 2'd1 && !bus.hub75_ready) bus.hub75_ready = 1'b1;
            else bus.hub75_ready = 1'b0;
        end
        check("t4_reach", hit, 1);
        step();
        check("t4_no_dv", bus.data_valid, 0);
        check("t4_restart", bus.gen_col_index, 0);
        pulse_loop(100, 5);
        check("t4_count", got_q.size() >= 5, 1);
        if (got_q.size() >= 5) begin
            check("t4_pre", got_q[2], 2);
            check("t4_after", got_q[3], 0);
            check("t4_next", got_q[4], 1);
        end
        check("t4_abort", bus.abort_count, STATS ? 1 : 0);

        // Async reset while stalled waiting for ready.
        bus.hub75_ready = 1'b0;
        bus.col_mask    = 32'h0000_00F0;
        bus.dtheta      = 8'd7;
        k = 0;
        for (int c = 0; c < 200 && k < 3; c++) begin
            step();
            if (bus.state_dbg == 2'd2) k++;
            else k = 0;
        end
        check("t5_stall", k, 3);
        #1 rst_in = 1'b1;
        #1;
        check("t5_dv", bus.data_valid, 0);
        check("t5_load", bus.load_col, 0);
        check("t5_c1", bus.col_num1, 0);
        check("t5_c2", bus.col_num2, 0);
        check("t5_gen", bus.gen_col_index, 0);
        check("t5_done", bus.sweep_done, 0);
        check("t5_abort", bus.abort_count, 0);
        repeat (2) step();
        bus.dtheta      = '0;
        bus.col_mask    = '1;
        bus.hub75_ready = 1'b1;
        got_q.delete();
        rst_in = 1'b0;
        // Ready held high: only its single rising edge is a request.
        repeat (200) step();
        check("t6_one", got_q.size(), 1);
        if (got_q.size() >= 1) check("t6_first", got_q[0], 0);

        // Random phase.
        bus.col_mask = $urandom();
        for (int c = 0; c < 3000; c++) begin
            step();
            if ($urandom_range(0, 199) == 0) bus.dtheta = 8'($urandom_range(0, RR - 1));
            if ($urandom_range(0, 299) == 0) bus.col_mask = $urandom() & $urandom();
            if ($urandom_range(0, 3) == 0) bus.hub75_ready = ~bus.hub75_ready;
        end
        step();
        check("sb_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
